// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage registers: skid state
// encoding, default widths and the payload field map used by the core stages.
package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_e;

    localparam int PIPE_PAYLOAD_W_DEF = 256;
    localparam int PIPE_CNT_W_DEF     = 32;

    // ID/EX payload packing: pc, rs1/rs2 operands, immediate, rd, control.
    localparam int IDEX_PC_LSB    = 0;
    localparam int IDEX_RS1_LSB   = 32;
    localparam int IDEX_RS2_LSB   = 64;
    localparam int IDEX_IMM_LSB   = 96;
    localparam int IDEX_RD_LSB    = 128;
    localparam int IDEX_CTRL_LSB  = 133;

    // EX/MEM payload packing: alu result, store data, rd, control.
    localparam int EXMEM_ALU_LSB  = 0;
    localparam int EXMEM_STD_LSB  = 32;
    localparam int EXMEM_RD_LSB   = 64;
    localparam int EXMEM_CTRL_LSB = 69;

    // MEM/WB payload packing: writeback value, rd, write enable.
    localparam int MEMWB_WB_LSB   = 0;
    localparam int MEMWB_RD_LSB   = 32;
    localparam int MEMWB_WE_LSB   = 37;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid bit plus payload register. Clear wins over load
// and only drops the valid bit; the payload changes only on load.
module pipe_slot #(
    parameter int W = 256
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and a saturating bubble counter.
// Define PIPE_SKID_EN for a skid slot and a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = PIPE_PAYLOAD_W_DEF,
    parameter int CNT_W     = PIPE_CNT_W_DEF
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CNT_W-1:0]     bubble_cnt
);

    logic                 main_load, main_clear, main_valid;
    logic [PAYLOAD_W-1:0] main_d, main_data;

`ifdef PIPE_SKID_EN
    pipe_state_e          state_q, state_d;
    logic                 skid_load, skid_clear, skid_valid, main_from_skid;
    logic [PAYLOAD_W-1:0] skid_data;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= PIPE_EMPTY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d    = PIPE_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                PIPE_EMPTY: if (in_valid) begin
                    main_load = 1'b1;
                    state_d   = PIPE_ONE;
                end
                PIPE_ONE: case ({in_valid, out_ready})
                    2'b11:   main_load = 1'b1;
                    2'b10: begin
                        skid_load = 1'b1;
                        state_d   = PIPE_FULL;
                    end
                    2'b01: begin
                        main_clear = 1'b1;
                        state_d    = PIPE_EMPTY;
                    end
                    default: state_d = PIPE_ONE;
                endcase
                PIPE_FULL: if (out_ready) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                    state_d        = PIPE_ONE;
                end
                default: state_d = PIPE_EMPTY;
            endcase
        end
    end

    // skid valid is set exactly in FULL, so this is a pure register output
    assign in_ready = !skid_valid;
    assign main_d   = main_from_skid ? skid_data : in_payload;

    pipe_slot #(.W(PAYLOAD_W)) u_skid (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_payload),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );
`else
    logic in_hs, out_hs;

    assign in_ready   = !main_valid || out_ready;
    assign in_hs      = in_valid && in_ready;
    assign out_hs     = main_valid && out_ready;
    assign main_load  = in_hs && !flush;
    assign main_clear = flush || (out_hs && !in_hs);
    assign main_d     = in_payload;
`endif

    pipe_slot #(.W(PAYLOAD_W)) u_main (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (main_d),
        .valid_o (main_valid),
        .data_o  (main_data)
    );

    assign out_valid   = main_valid;
    assign out_payload = main_data;

    logic [CNT_W-1:0] bubble_q, bubble_d;

    always_comb begin
        bubble_d = bubble_q;
        if (out_ready && !main_valid && (bubble_q != {CNT_W{1'b1}}))
            bubble_d = bubble_q + CNT_W'(1);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) bubble_q <= '0;
        else         bubble_q <= bubble_d;
    end

    assign bubble_cnt = bubble_q;

endmodule
